// File: rtl/fx_accum_pkg.sv
// fx_accum_pkg: shared types and constants for the fixed-point accumulate/dump path.
//   state_t          : accumulator FSM state (IDLE, ACCUM)
//   clog2()          : ceiling log2 for sizing counters
//   out_max/out_min(): two's-complement limits for a given width
//   OUT_MAX/OUT_MIN  : limits for the default 12-bit output width
package fx_accum_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   function automatic int out_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int out_min(input int w);
      return -(1 << (w - 1));
   endfunction

   localparam int DEF_OUT_W = 12;
   localparam int OUT_MAX   = out_max(DEF_OUT_W);
   localparam int OUT_MIN   = out_min(DEF_OUT_W);

endpackage

// File: rtl/fx_shift_sat.sv
// fx_shift_sat: combinational arithmetic right shift, optional round-half-up,
// and saturation from an ACC_W-bit signed value to an OUT_W-bit signed value.
// Optional feature macro: FX_ACCUM_ROUND_EN (round half up before saturating;
// undefined = truncation toward minus infinity).
// Ports:
//   sum_in  : ACC_W-bit two's-complement input
//   res_out : OUT_W-bit two's-complement shifted, saturated result
import fx_accum_pkg::*;

module fx_shift_sat #(
   parameter int ACC_W = 16,
   parameter int OUT_W = 12,
   parameter int SHIFT = 3
) (
   input  logic [ACC_W-1:0] sum_in,
   output logic [OUT_W-1:0] res_out
);

   // One extra bit so the rounding increment can never wrap.
   localparam int EW = ACC_W + 1;
   localparam logic signed [EW-1:0] MAXV =
      EW'((OUT_W == DEF_OUT_W) ? OUT_MAX : out_max(OUT_W));
   localparam logic signed [EW-1:0] MINV =
      EW'((OUT_W == DEF_OUT_W) ? OUT_MIN : out_min(OUT_W));

`ifdef FX_ACCUM_ROUND_EN
   localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [EW-1:0] RND = EW'(1) << RS;
`endif

   logic signed [ACC_W-1:0] sum_x;
   logic signed [EW-1:0]    ext;
   logic signed [EW-1:0]    shf;

   function automatic logic signed [EW-1:0] round_half_up(input logic signed [EW-1:0] v);
`ifdef FX_ACCUM_ROUND_EN
      if (SHIFT > 0) return v + RND;
      else return v;
`else
      return v;
`endif
   endfunction

   function automatic logic signed [OUT_W-1:0] sat(input logic signed [EW-1:0] v);
      if (v > MAXV) return MAXV[OUT_W-1:0];
      else if (v < MINV) return MINV[OUT_W-1:0];
      else return v[OUT_W-1:0];
   endfunction

   always_comb begin
      sum_x   = sum_in;
      ext     = EW'(sum_x);
      shf     = round_half_up(ext) >>> SHIFT;
      res_out = sat(shf);
   end

endmodule

// File: rtl/fx_accum_dump.sv
// fx_accum_dump: integrates LEN valid signed samples in an ACC_W-bit
// accumulator, then dumps one shifted, saturated result per block into an
// output register with a valid/ready handshake, and restarts.
// Optional feature macro: FX_ACCUM_ROUND_EN (round half up in fx_shift_sat).
// Ports:
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_data/i_valid : signed sample stream from the subtract stage
//   i_clear        : synchronous abort of the block in progress (wins over i_valid)
//   o_data/o_valid : dumped result, held until o_valid && i_ready
//   i_ready        : downstream accept
//   o_drop         : one-cycle pulse when an unconsumed result is overwritten
//   o_busy         : a block is partially accumulated
import fx_accum_pkg::*;

module fx_accum_dump #(
   parameter int DATA_W = 12,
   parameter int LEN    = 8,
   parameter int ACC_W  = 16,
   parameter int SHIFT  = 3,
   parameter int OUT_W  = 12
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   input  logic              i_clear,
   output logic [OUT_W-1:0]  o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_drop,
   output logic              o_busy
);

   localparam int CNT_W = clog2(LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   state_t                  state_p0, state_nx;
   logic signed [ACC_W-1:0] acc_p0, acc_nx;
   logic [CNT_W-1:0]        cnt_p0, cnt_nx;
   logic signed [DATA_W-1:0] din;
   logic signed [ACC_W-1:0] din_x;
   logic signed [ACC_W-1:0] sum;
   logic [OUT_W-1:0]        res;
   logic                    dump;
   logic                    hs;

   assign din   = i_data;
   assign din_x = ACC_W'(din);
   assign sum   = acc_p0 + din_x;
   // LEN >= 2, so the dump sample always arrives in ACCUM.
   assign dump  = (state_p0 == ACCUM) && i_valid && !i_clear && (cnt_p0 == LAST);
   assign hs    = o_valid && i_ready;
   assign o_busy = (state_p0 == ACCUM);

   fx_shift_sat #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_shift_sat (
      .sum_in  (sum),
      .res_out (res)
   );

   always_comb begin
      state_nx = state_p0;
      acc_nx   = acc_p0;
      cnt_nx   = cnt_p0;
      if (i_clear) begin
         state_nx = IDLE;
         acc_nx   = '0;
         cnt_nx   = '0;
      end else if (i_valid) begin
         case (state_p0)
            IDLE: begin
               state_nx = ACCUM;
               acc_nx   = din_x;
               cnt_nx   = CNT_W'(1);
            end
            ACCUM: begin
               if (cnt_p0 == LAST) begin
                  state_nx = IDLE;
                  acc_nx   = '0;
                  cnt_nx   = '0;
               end else begin
                  acc_nx = sum;
                  cnt_nx = cnt_p0 + CNT_W'(1);
               end
            end
            default: begin
               state_nx = IDLE;
               acc_nx   = '0;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   // Stage p0: accumulator state
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_p0 <= IDLE;
         acc_p0   <= '0;
         cnt_p0   <= '0;
      end else begin
         state_p0 <= state_nx;
         acc_p0   <= acc_nx;
         cnt_p0   <= cnt_nx;
      end
   end

   // Stage p1: output register and handshake
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data  <= '0;
         o_valid <= 1'b0;
         o_drop  <= 1'b0;
      end else begin
         o_drop <= dump && o_valid && !i_ready;
         if (dump) begin
            o_data  <= res;
            o_valid <= 1'b1;
         end else if (hs) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fx_accum_dump.sv
module tb_fx_accum_dump;

   logic        clk;
   logic        rst_n;
   logic [11:0] i_data;
   logic        i_valid;
   logic        i_clear;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        i_ready;
   logic        o_drop;
   logic        o_busy;

   int total;
   int bad;
   int exp_q[$];
   int busy_cnt;
   int valid_cnt;
   int drop_cnt;
   logic prev_valid;
   logic prev_hs;

   fx_accum_dump #(
      .DATA_W (12),
      .LEN    (4),
      .ACC_W  (16),
      .SHIFT  (2),
      .OUT_W  (8)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_data  (i_data),
      .i_valid (i_valid),
      .i_clear (i_clear),
      .o_data  (o_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_drop  (o_drop),
      .o_busy  (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      i_data  = 12'(v);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic send4(input int v, input int exp);
      exp_q.push_back(exp);
      for (int k = 0; k < 4; k++) send(v);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // Monitor: a new result is on the output when o_valid rises, when a dump
   // coincides with a handshake, or when an unconsumed result is overwritten.
   always @(negedge clk) begin
      if (o_valid && (!prev_valid || prev_hs || o_drop)) begin
         if (exp_q.size() == 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL unexpected_result: got=%0d expected=none", $signed(o_data));
         end else begin
            check("result", $signed(o_data), exp_q.pop_front());
         end
      end
      if (o_busy)  busy_cnt  <= busy_cnt + 1;
      if (o_valid) valid_cnt <= valid_cnt + 1;
      if (o_drop)  drop_cnt  <= drop_cnt + 1;
      prev_valid <= o_valid;
      prev_hs    <= o_valid && i_ready;
   end

   initial begin
      int b0, v0, d0;
      total = 0; bad = 0;
      busy_cnt = 0; valid_cnt = 0; drop_cnt = 0;
      prev_valid = 1'b0; prev_hs = 1'b0;
      i_data = '0; i_valid = 1'b0; i_clear = 1'b0; i_ready = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("reset_o_valid", int'(o_valid), 0);
      check("reset_o_data", int'(o_data), 0);
      check("reset_o_busy", int'(o_busy), 0);
      check("reset_o_drop", int'(o_drop), 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // 1: basic dump, ready high
      i_ready = 1'b1;
      b0 = busy_cnt; v0 = valid_cnt; d0 = drop_cnt;
      exp_q.push_back(25);
      send(10); send(20); send(30); send(40);
      check("latency_o_valid", int'(o_valid), 1);
      idle(3);
      check("busy_cycles", busy_cnt - b0, 3);
      check("valid_cycles", valid_cnt - v0, 1);
      check("basic_no_drop", drop_cnt - d0, 0);

      // 2: rounding
`ifdef FX_ACCUM_ROUND_EN
      exp_q.push_back(1);
`else
      exp_q.push_back(0);
`endif
      send(1); send(1); send(1); send(0);
      idle(2);
      exp_q.push_back(-1);
      send(-1); send(-1); send(-1); send(0);
      idle(2);

      // 3: saturation
      send4(2047, 127);
      idle(2);
      send4(-2048, -128);
      idle(2);

      // 4: backpressure, overwrite, then handshake
      i_ready = 1'b0;
      d0 = drop_cnt;
      send4(10, 10);
      idle(2);
      send4(20, 20);
      idle(2);
      check("bp_drop_count", drop_cnt - d0, 1);
      check("bp_valid_held", int'(o_valid), 1);
      check("bp_data", $signed(o_data), 20);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check("bp_valid_fall", int'(o_valid), 0);
      // dump in the same cycle as a handshake: new result, no drop
      send4(4, 4);
      d0 = drop_cnt;
      send(8); send(8); send(8);
      exp_q.push_back(8);
      i_ready = 1'b1;
      send(8);
      check("coincide_valid", int'(o_valid), 1);
      check("coincide_data", $signed(o_data), 8);
      idle(2);
      check("coincide_no_drop", drop_cnt - d0, 0);

      // 5: gaps and clear with a pending result
      i_ready = 1'b0;
      send4(6, 6);
      send(5); idle(3); send(5); idle(2);
      check("gap_busy_held", int'(o_busy), 1);
      i_clear = 1'b1; i_valid = 1'b1; i_data = 12'(7);
      tick();
      i_clear = 1'b0; i_valid = 1'b0;
      check("clear_busy", int'(o_busy), 0);
      check("clear_keeps_valid", int'(o_valid), 1);
      check("clear_keeps_data", $signed(o_data), 6);
      i_ready = 1'b1;
      idle(1);
      send4(8, 8);
      idle(2);

      // 6: asynchronous reset mid-block with a pending result
      i_ready = 1'b0;
      send4(20, 20);
      send(100); send(100);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_o_valid", int'(o_valid), 0);
      check("async_rst_o_data", int'(o_data), 0);
      check("async_rst_o_busy", int'(o_busy), 0);
      check("async_rst_o_drop", int'(o_drop), 0);
      tick();
      rst_n = 1'b1;
      i_ready = 1'b1;
      idle(1);
      send4(12, 12);
      idle(3);
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
